// File: rtl/mem_pipe_resp.sv
// mem_pipe_resp: 2^AW x 16-bit word memory with LAT-cycle fully pipelined read responses.
// Optional MEM_ADDR_CHECK_EN adds an err output flagging addresses beyond the array.
module mem_pipe_resp #(
    parameter int AW  = 15,
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic        err
`endif
);
    localparam int DEPTH = 1 << AW;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic          addr_bad;
    logic          do_write;
    logic          do_read;
    logic [15:0]   rd_word;
    logic          pipe_valid [LAT];
    logic [15:0]   pipe_data  [LAT];
    logic          unused_addr;

    assign word_idx    = addr[AW:1];
    assign unused_addr = ^addr;

`ifdef MEM_ADDR_CHECK_EN
    assign addr_bad = (addr >> (AW + 1)) != 16'h0000;
`else
    assign addr_bad = 1'b0;
`endif

    assign do_write = enable & wr & ~addr_bad;
    assign do_read  = enable & ~wr;
    assign rd_word  = addr_bad ? 16'h0000 : mem[word_idx];

    // Array has no reset; writes are simply gated off while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && do_write) begin
            mem[word_idx] <= data_in;
        end
    end

    // Read data is captured at issue, so later writes never disturb an in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= 16'h0000;
            end
        end else begin
            pipe_valid[0] <= do_read;
            pipe_data[0]  <= do_read ? rd_word : 16'h0000;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign data_valid = pipe_valid[LAT-1];
    assign data_out   = pipe_data[LAT-1];

`ifdef MEM_ADDR_CHECK_EN
    logic pipe_err [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_err[i] <= 1'b0;
            end
        end else begin
            pipe_err[0] <= enable & addr_bad;
            for (int i = 1; i < LAT; i++) begin
                pipe_err[i] <= pipe_err[i-1];
            end
        end
    end

    assign err = pipe_err[LAT-1];
`endif

endmodule

// File: tb/tb_mem_pipe_resp.sv
// tb_mem_pipe_resp: scoreboard bench for mem_pipe_resp with a word-array reference model.
// Directed scenarios followed by randomized traffic with aliased addresses.
module tb_mem_pipe_resp;
    localparam int AW    = 10;
    localparam int LAT   = 4;
    localparam int DEPTH = 1 << AW;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        wr      = 1'b0;
    logic [15:0] addr    = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_valid;
    logic        err;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
    assign err = 1'b0;
`endif

    mem_pipe_resp #(.AW(AW), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid)
`ifdef MEM_ADDR_CHECK_EN
        ,
        .err        (err)
`endif
    );

    typedef struct {
        bit          rd;
        bit          er;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] model_mem [DEPTH];
    int          cyc    = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: word = (byte address / 2) mod depth, read data fixed at issue.
    task automatic model_request(input bit w, input logic [15:0] a, input logic [15:0] d);
        int   idx;
        bit   bad;
        exp_t e;
        idx   = int'(a >> 1) % DEPTH;
        bad   = CHECK_EN && ((a >> (AW + 1)) != 16'h0000);
        e.due = cyc + LAT;
        e.er  = bad;
        if (w) begin
            if (!bad) model_mem[idx] = d;
            if (bad) begin
                e.rd   = 1'b0;
                e.data = 16'h0000;
                exp_q.push_back(e);
            end
        end else begin
            e.rd   = 1'b1;
            e.data = bad ? 16'h0000 : model_mem[idx];
            exp_q.push_back(e);
        end
    endtask

    task automatic apply_stimulus(input bit en, input bit w, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        #1;
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        if (en) model_request(w, a, d);
    endtask

    // One-cycle reset pulse; a write offered during reset must be dropped, and a read
    // is presented as reset releases so the first post-reset edge accepts it.
    task automatic reset_pulse(input logic [15:0] read_addr);
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = read_addr;
        data_in = 16'hFFFF;
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        enable  = 1'b1;
        wr      = 1'b0;
        addr    = read_addr;
        data_in = 16'h0000;
        model_request(1'b0, read_addr, 16'h0000);
    endtask

    // Monitor pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (data_valid || err) begin
            check_output("pending_expectation", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("data_valid", 32'(data_valid), 32'(e.rd));
                check_output("err", 32'(err), 32'(e.er));
                check_output("data_out", 32'(data_out), 32'(e.data));
                check_output("latency", 32'(cyc), 32'(e.due));
            end
        end else begin
            check_output("idle_data_out", 32'(data_out), 32'h0);
        end
    end

    logic [15:0] rand_addr;

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        check_output("reset_valid", 32'(data_valid), 32'h0);

        #1;
        rst_n   = 1'b1;
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0000;
        data_in = 16'h0001;
        model_request(1'b1, 16'h0000, 16'h0001);
        for (int i = 1; i < 64; i++) begin
            apply_stimulus(1'b1, 1'b1, 16'(i * 2), 16'(i + 1));
        end

        apply_stimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        apply_stimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 16'(i * 2), 16'h0000);
        end

        apply_stimulus(1'b1, 1'b1, 16'h0020, 16'h1111);
        apply_stimulus(1'b1, 1'b0, 16'h0020, 16'h0000);
        apply_stimulus(1'b1, 1'b1, 16'h0020, 16'h2222);
        apply_stimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
        apply_stimulus(1'b1, 1'b0, 16'h0020, 16'h0000);

        apply_stimulus(1'b1, 1'b1, 16'h0030, 16'h5A5A);
        apply_stimulus(1'b1, 1'b0, 16'h0030, 16'h0000);
        apply_stimulus(1'b1, 1'b0, 16'h0032, 16'h0000);
        reset_pulse(16'h0030);
        apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);

        apply_stimulus(1'b1, 1'b1, 16'h0040, 16'h7777);
        apply_stimulus(1'b0, 1'b1, 16'h0040, 16'hDEAD);
        apply_stimulus(1'b1, 1'b0, 16'h0041, 16'h0000);

        apply_stimulus(1'b1, 1'b1, 16'h8000, 16'h3C3C);
        apply_stimulus(1'b1, 1'b0, 16'h8000, 16'h0000);
        apply_stimulus(1'b1, 1'b0, 16'h0000, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            rand_addr        = 16'($urandom_range(0, 63)) << 1;
            rand_addr[0]     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) rand_addr[15:11] = 5'($urandom_range(0, 31));
            apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                           rand_addr, 16'($urandom));
        end

        apply_stimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2 * LAT + 4) @(negedge clk);
        check_output("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
